// File: rtl/tinycpu_sequencer.sv
// tinycpu_sequencer: issues program memory words to the TinyCPU In bus, free-running or single-stepped.
// Define SEQ_ISSUE_COUNT_EN to add the saturating o_issue_count output.
module tinycpu_sequencer #(
    parameter int          AW      = 4,
    parameter logic [3:0]  HALT_OP = 4'hF,
    parameter logic [3:0]  NOP_OP  = 4'h0
) (
    input  logic          i_clk,
    input  logic          i_clr,
    input  logic          i_prog_we,
    input  logic [AW-1:0] i_prog_addr,
    input  logic [11:0]   i_prog_wdata,
    input  logic          i_start,
    input  logic          i_abort,
    input  logic          i_step_mode,
    input  logic          i_step,
    output logic [11:0]   o_cpu_in,
    output logic          o_issue_valid,
    output logic [AW-1:0] o_pc,
    output logic          o_busy,
    output logic          o_done
`ifdef SEQ_ISSUE_COUNT_EN
    ,
    output logic [15:0]   o_issue_count
`endif
);
    localparam int DEPTH = 2**AW;
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;
    localparam logic [11:0] NOP_WORD = {NOP_OP, 8'h00};

    logic [11:0]   r_mem [DEPTH];
    logic [1:0]    r_state;
    logic [AW-1:0] r_pc;
    logic [11:0]   r_cpu_in;
    logic          r_issue_valid;
    logic [11:0]   w_word;
    logic          w_abort, w_start, w_slot, w_halt, w_issue;

    assign w_word  = r_mem[r_pc];
    assign w_abort = i_abort && r_state != S_IDLE;
    assign w_start = i_start && r_state != S_RUN && !w_abort;
    assign w_slot  = r_state == S_RUN && (!i_step_mode || i_step);
    assign w_halt  = w_word[11:8] == HALT_OP;
    assign w_issue = w_slot && !w_halt && !i_abort;

    always_ff @(posedge i_clk)
        if (i_prog_we && r_state != S_RUN) r_mem[i_prog_addr] <= i_prog_wdata;

    always_ff @(posedge i_clk) begin
        if (i_clr) begin
            r_state       <= S_IDLE;
            r_pc          <= '0;
            r_cpu_in      <= NOP_WORD;
            r_issue_valid <= 1'b0;
        end else begin
            r_issue_valid <= w_issue;
            r_cpu_in      <= w_issue ? w_word : NOP_WORD;
            if (w_abort) r_state <= S_IDLE;
            else if (w_start) begin
                r_state <= S_RUN;
                r_pc    <= '0;
            end else if (w_slot) begin
                if (w_halt) r_state <= S_DONE;
                else begin
                    // issuing the last word ends the run; pc wraps to 0
                    r_pc <= r_pc + 1'b1;
                    if (&r_pc) r_state <= S_DONE;
                end
            end
        end
    end

`ifdef SEQ_ISSUE_COUNT_EN
    logic [15:0] r_issue_count;
    always_ff @(posedge i_clk) begin
        if (i_clr || w_start) r_issue_count <= '0;
        else if (w_issue && r_issue_count != 16'hFFFF) r_issue_count <= r_issue_count + 1'b1;
    end
    assign o_issue_count = r_issue_count;
`endif

    assign o_cpu_in      = r_cpu_in;
    assign o_issue_valid = r_issue_valid;
    assign o_pc          = r_pc;
    assign o_busy        = r_state == S_RUN;
    assign o_done        = r_state == S_DONE;
endmodule

// File: tb/tb_tinycpu_sequencer.sv
// tb_tinycpu_sequencer: randomized and directed scenarios checked against a program-level reference model.
module tb_tinycpu_sequencer;
    logic        clk = 1'b0, clr = 1'b1, prog_we = 1'b0, start = 1'b0, abort = 1'b0;
    logic        step_mode = 1'b0, step = 1'b0;
    logic [3:0]  prog_addr = '0;
    logic [11:0] prog_wdata = '0;
    logic [11:0] cpu_in;
    logic        issue_valid, busy, done;
    logic [3:0]  pc;
    logic [11:0] m [16];
    int checks = 0, errors = 0;
`ifdef SEQ_ISSUE_COUNT_EN
    logic [15:0] issue_count;
`endif

    tinycpu_sequencer dut (
        .i_clk(clk), .i_clr(clr), .i_prog_we(prog_we), .i_prog_addr(prog_addr),
        .i_prog_wdata(prog_wdata), .i_start(start), .i_abort(abort),
        .i_step_mode(step_mode), .i_step(step), .o_cpu_in(cpu_in),
        .o_issue_valid(issue_valid), .o_pc(pc), .o_busy(busy), .o_done(done)
`ifdef SEQ_ISSUE_COUNT_EN
        , .o_issue_count(issue_count)
`endif
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // expected run length: words from address 0 up to the first halt, or the whole memory
    function automatic int exp_len();
        for (int i = 0; i < 16; i++) if (m[i][11:8] == 4'hF) return i;
        return 16;
    endfunction

    task automatic load(input logic [3:0] a, input logic [11:0] w);
        prog_we = 1'b1; prog_addr = a; prog_wdata = w;
        tick();
        prog_we = 1'b0;
        m[a] = w;
    endtask

    task automatic load_random(input int halt_at);
        for (int i = 0; i < 16; i++) begin
            logic [11:0] w;
            w = {4'($urandom_range(0, 14)), 8'($urandom)};
            if (i == halt_at) w[11:8] = 4'hF;
            load(4'(i), w);
        end
    endtask

    task automatic run_free(input string name);
        int n, cyc;
        logic [11:0] q [$];
        n = exp_len();
        cyc = 0;
        start = 1'b1;
        tick();
        start = 1'b0;
        checks++;
        if (busy !== 1'b1 || done !== 1'b0) begin
            errors++; $display("FAIL %s start: busy=%b done=%b, need busy=1 done=0", name, busy, done);
        end
        while (!done && cyc < 40) begin
            tick();
            cyc++;
            if (issue_valid) q.push_back(cpu_in);
            else begin
                checks++;
                if (cpu_in !== 12'h000) begin
                    errors++; $display("FAIL %s idle_nop: cpu_in=%h need 000", name, cpu_in);
                end
            end
        end
        checks++;
        if (q.size() != n || cyc >= 40) begin
            errors++; $display("FAIL %s count: issued=%0d cycles=%0d, need %0d issues", name, q.size(), cyc, n);
        end
        for (int i = 0; i < q.size() && i < n; i++) begin
            checks++;
            if (q[i] !== m[i]) begin
                errors++; $display("FAIL %s word%0d: got %h need %h", name, i, q[i], m[i]);
            end
        end
        checks++;
        if (pc !== 4'(n) || busy !== 1'b0) begin
            errors++; $display("FAIL %s end: pc=%0d busy=%b, need pc=%0d busy=0", name, pc, busy, 4'(n));
        end
`ifdef SEQ_ISSUE_COUNT_EN
        checks++;
        if (issue_count !== 16'(n)) begin
            errors++; $display("FAIL %s issue_count: got %0d need %0d", name, issue_count, n);
        end
`endif
        repeat (3) begin
            tick();
            checks++;
            if (issue_valid !== 1'b0 || cpu_in !== 12'h000 || done !== 1'b1) begin
                errors++; $display("FAIL %s after_done: iv=%b cpu_in=%h done=%b, need 0 000 1", name, issue_valid, cpu_in, done);
            end
        end
    endtask

    task automatic run_step(input string name, input int gmin, input int gmax);
        int n, pulses;
        n = exp_len();
        pulses = (n < 16) ? n + 1 : 16;
        step_mode = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int p = 0; p < pulses; p++) begin
            repeat ($urandom_range(gmin, gmax)) begin
                tick();
                checks++;
                if (issue_valid !== 1'b0 || cpu_in !== 12'h000 || busy !== 1'b1) begin
                    errors++; $display("FAIL %s gap%0d: iv=%b cpu_in=%h busy=%b, need 0 000 1", name, p, issue_valid, cpu_in, busy);
                end
            end
            step = 1'b1;
            tick();
            step = 1'b0;
            checks++;
            if (p < n) begin
                if (issue_valid !== 1'b1 || cpu_in !== m[p]) begin
                    errors++; $display("FAIL %s pulse%0d: iv=%b cpu_in=%h, need 1 %h", name, p, issue_valid, cpu_in, m[p]);
                end
            end else if (issue_valid !== 1'b0 || done !== 1'b1) begin
                errors++; $display("FAIL %s halt_pulse: iv=%b done=%b, need 0 1", name, issue_valid, done);
            end
        end
        checks++;
        if (done !== 1'b1 || busy !== 1'b0) begin
            errors++; $display("FAIL %s step_done: done=%b busy=%b, need 1 0", name, done, busy);
        end
        step_mode = 1'b0;
    endtask

    task automatic test_reset();
        repeat (2) tick();
        clr = 1'b0;
        checks++;
        if (cpu_in !== 12'h000 || issue_valid !== 1'b0 || pc !== 4'd0 || busy !== 1'b0 || done !== 1'b0) begin
            errors++; $display("FAIL reset: cpu_in=%h iv=%b pc=%0d busy=%b done=%b, need 000 0 0 0 0", cpu_in, issue_valid, pc, busy, done);
        end
    endtask

    task automatic test_basic();
        load(0, 12'h105); load(1, 12'h203); load(2, 12'hF00);
        run_free("basic");
        run_step("step3", 2, 2);
    endtask

    task automatic test_full_memory();
        for (int i = 0; i < 16; i++) load(4'(i), 12'h101 + 12'(i));
        run_free("full16");
        run_step("full16_step", 0, 2);
    endtask

    task automatic test_random();
        for (int k = 0; k < 6; k++) begin
            load_random($urandom_range(0, 16));
            run_free("rand_free");
        end
        for (int k = 0; k < 3; k++) begin
            load_random($urandom_range(0, 16));
            run_step("rand_step", 0, 3);
        end
    endtask

    task automatic test_abort();
        load_random(10);
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        checks++;
        if (issue_valid !== 1'b1 || cpu_in !== m[1]) begin
            errors++; $display("FAIL abort_pre: iv=%b cpu_in=%h, need 1 %h", issue_valid, cpu_in, m[1]);
        end
        abort = 1'b1;
        tick();
        abort = 1'b0;
        repeat (4) begin
            checks++;
            if (busy !== 1'b0 || done !== 1'b0 || issue_valid !== 1'b0 || cpu_in !== 12'h000) begin
                errors++; $display("FAIL abort: busy=%b done=%b iv=%b cpu_in=%h, need 0 0 0 000", busy, done, issue_valid, cpu_in);
            end
            tick();
        end
    endtask

    task automatic test_write_guard();
        load(0, 12'h105); load(1, 12'h203); load(2, 12'hF00);
        start = 1'b1;
        tick();
        start = 1'b0;
        prog_we = 1'b1; prog_addr = 4'd1; prog_wdata = 12'h2AA;
        tick();
        prog_we = 1'b0;
        tick();
        checks++;
        if (issue_valid !== 1'b1 || cpu_in !== 12'h203) begin
            errors++; $display("FAIL we_in_run: iv=%b cpu_in=%h, need 1 203", issue_valid, cpu_in);
        end
        repeat (2) tick();
        checks++;
        if (done !== 1'b1) begin
            errors++; $display("FAIL we_done: done=%b need 1", done);
        end
        load(1, 12'h2AA);
        run_free("we_in_done");
    endtask

    task automatic test_clr_midrun();
        load(0, 12'h105); load(1, 12'h203); load(2, 12'hF00);
        run_free("pre_clr");
        load_random(12);
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (4) tick();
        clr = 1'b1;
        tick();
        clr = 1'b0;
        checks++;
        if (cpu_in !== 12'h000 || issue_valid !== 1'b0 || pc !== 4'd0 || busy !== 1'b0 || done !== 1'b0) begin
            errors++; $display("FAIL clr_mid: cpu_in=%h iv=%b pc=%0d busy=%b done=%b, need 000 0 0 0 0", cpu_in, issue_valid, pc, busy, done);
        end
`ifdef SEQ_ISSUE_COUNT_EN
        checks++;
        if (issue_count !== 16'd0) begin
            errors++; $display("FAIL clr_count: got %0d need 0", issue_count);
        end
`endif
        run_free("after_clr");
    endtask

    initial begin
        test_reset();
        test_basic();
        test_full_memory();
        test_random();
        test_abort();
        test_write_guard();
        test_clr_midrun();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/tinycpu_sequencer.md
Name: tinycpu_sequencer

Overview:
Program sequencer that drives the TinyCPU 12-bit instruction input. It holds a small program memory loaded through a write port, then issues one instruction per cycle, or one per step pulse in step mode, until it reaches a halt opcode or the end of memory. It sits between the board-level load/control logic and the TinyCPU In bus, and replaces manual switch entry of instructions.

Parameters:
AW, 4, program memory address width; DEPTH = 2**AW words of 12 bits
HALT_OP, 4'hF, opcode in word[11:8] that terminates the run; the halt word itself is never issued
NOP_OP, 4'h0, opcode driven on cpu_in whenever no instruction is being issued; the data field is then 8'h00

Ports:
Clk  input  1  system clock, rising edge
Clr  input  1  synchronous active-high reset
prog_we  input  1  program memory write strobe
prog_addr  input  AW  program memory write address
prog_wdata  input  12  program word: [11:8] opcode, [7:0] data
start  input  1  begin a run from address 0
abort  input  1  stop the run and return to IDLE
step_mode  input  1  1 = issue only on step pulses
step  input  1  single-cycle step request
cpu_in  output  12  registered word to the TinyCPU In bus
issue_valid  output  1  1-cycle pulse; cpu_in holds a newly issued instruction
pc  output  AW  address of the next word to fetch
busy  output  1  high in RUN
done  output  1  high in DONE

Behaviour:
- Reset (Clr=1 at a clock edge, in any state, including mid-run): state=IDLE, pc=0, cpu_in={NOP_OP,8'h00}, issue_valid=0, busy=0, done=0. Memory contents are not cleared.
- Memory: DEPTH x 12 registers, combinational read at pc.
  - Write on an edge when prog_we=1 and state!=RUN.
  - prog_we in RUN is ignored.
- Whenever issue_valid=0, cpu_in returns to {NOP_OP,8'h00} on the next edge.
- States: IDLE, RUN, DONE.
- IDLE:
  - start=1 -> RUN, pc<=0, busy<=1.
  - abort is ignored.
- RUN: an issue slot occurs each cycle when step_mode=0, or only in cycles where step=1 when step_mode=1. In an issue slot, w=mem[pc]:
  - w[11:8]==HALT_OP -> DONE, done<=1, busy<=0, no issue.
  - Otherwise: cpu_in<=w, issue_valid<=1, pc<=pc+1.
  - If the issued word is at pc==DEPTH-1 -> DONE on the same edge. pc wraps to 0 and there is no further issue.
  - Outside issue slots: issue_valid<=0, pc holds.
- abort=1 in RUN or DONE -> IDLE, busy<=0, done<=0, no issue. abort has priority over issue and halt.
- DONE:
  - start=1 -> RUN, pc<=0, done<=0, busy<=1.
  - prog_we is permitted.
- start in RUN is ignored.
- Priority: Clr > abort > start > issue.
- Latency:
  - start sampled at edge t -> mem[0] appears on cpu_in after edge t+1, with issue_valid=1 for the cycle following t+1.
  - Free-running throughput: 1 word/cycle.
- step_mode may change at any cycle; it takes effect at the next edge.

Optional Feature:
Macro SEQ_ISSUE_COUNT_EN.
- Defined: adds output issue_count [15:0].
  - Cleared by Clr and by each accepted start.
  - Increments on every edge that sets issue_valid=1.
  - Saturates at 16'hFFFF.
- Not defined: the port and counter are absent; all other behaviour is identical.

Test Plan:
1. Load mem[0..2]=12'h105,12'h203,12'hF00, start -> cpu_in shows 12'h105 then 12'h203 on consecutive cycles with issue_valid=1; then DONE, done=1, cpu_in=12'h000, pc=2.
2. Same program with step_mode=1, step pulses 3 cycles apart -> exactly one issue per pulse, cpu_in=12'h000 between pulses, done after the 3rd pulse.
3. All 16 words non-halt (12'h101..12'h110), start -> 16 consecutive issues, then DONE with pc=0 and no 17th issue.
4. abort asserted on the 2nd issue cycle of a 10-word run -> IDLE next edge, busy=0, done=0, no further issue_valid.
5. prog_we to addr 1 with 12'h2AA during RUN -> mem[1] unchanged and the issued word is the original; the same write in DONE takes effect on the next run.
6. Clr mid-run; with SEQ_ISSUE_COUNT_EN, a completed 3-word run gives issue_count=2 -> after Clr all outputs are at reset values, issue_count=0, and memory is preserved (a rerun issues the same words).
